// File: rtl/lvds_panel_pwr_seq_pkg.sv
// Shared state encoding, default timing and output decode for the LVDS panel
// power sequencer.
package lvds_panel_pwr_seq_pkg;

    // state       | meaning
    // ST_OFF      | everything off, waiting for a power request
    // ST_UP_VDD   | panel VDD on, waiting before releasing the TX
    // ST_UP_LVDS  | TX running, video passed, waiting before backlight on
    // ST_RUN      | fully up, backlight on
    // ST_DN_BL    | backlight off, waiting before TX disable
    // ST_DN_LVDS  | TX held in reset, waiting before VDD off
    // ST_COOLDOWN | VDD off, minimum off-time before a new power-up
    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_UP_VDD   = 3'd1,
        ST_UP_LVDS  = 3'd2,
        ST_RUN      = 3'd3,
        ST_DN_BL    = 3'd4,
        ST_DN_LVDS  = 3'd5,
        ST_COOLDOWN = 3'd6
    } state_t;

    localparam int DEF_CLK_PER_TICK = 75;
    localparam int DEF_CNT_W        = 20;
    localparam int DEF_T_VDD_LVDS   = 20000;
    localparam int DEF_T_LVDS_BL    = 200000;
    localparam int DEF_T_BL_LVDS    = 200000;
    localparam int DEF_T_LVDS_VDD   = 20000;
    localparam int DEF_T_OFF_MIN    = 500000;

    typedef struct packed {
        logic vdd_en;
        logic tx_on;   // drives both TX reset release and video enable
        logic bl_on;   // drives both backlight enable and ready
    } outs_t;

    // Output levels that belong to a given state.
    function automatic outs_t decode_outs(input state_t s);
        outs_t o;
        o.vdd_en = (s == ST_UP_VDD) || (s == ST_UP_LVDS) || (s == ST_RUN) ||
                   (s == ST_DN_BL)  || (s == ST_DN_LVDS);
        o.tx_on  = (s == ST_UP_LVDS) || (s == ST_RUN) || (s == ST_DN_BL);
        o.bl_on  = (s == ST_RUN);
        return o;
    endfunction

endpackage

// File: rtl/lvds_panel_pwr_seq_tick.sv
// Timebase prescaler: counts 0..CLK_PER_TICK-1 and flags the terminal count.
// A synchronous clear restarts the count so each state's timing starts fresh.
module lvds_panel_pwr_seq_tick #(
    parameter int CLK_PER_TICK = 75
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_TICK - 1);

    logic [PW-1:0] cnt;

    // Wrap at terminal count; clear and reset both restart from zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/lvds_panel_pwr_seq.sv
// LVDS panel power sequencer: orders VDD, TX and backlight on the way up and
// tears them down in reverse on request drop, PLL unlock or fault.
module lvds_panel_pwr_seq
    import lvds_panel_pwr_seq_pkg::*;
#(
    parameter int CLK_PER_TICK = DEF_CLK_PER_TICK,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int T_VDD_LVDS   = DEF_T_VDD_LVDS,
    parameter int T_LVDS_BL    = DEF_T_LVDS_BL,
    parameter int T_BL_LVDS    = DEF_T_BL_LVDS,
    parameter int T_LVDS_VDD   = DEF_T_LVDS_VDD,
    parameter int T_OFF_MIN    = DEF_T_OFF_MIN
) (
    input  logic       I_pix_clk,
    input  logic       I_rst_n,
    input  logic       I_power_req,
    input  logic       I_pll_lock,
    input  logic       I_fault,
    output logic       O_vdd_en,
    output logic       O_tx_rst_n,
    output logic       O_video_en,
    output logic       O_bl_en,
    output logic       O_ready,
    output logic [2:0] O_state
);

    localparam logic [CNT_W-1:0] LIM_VDD_LVDS = CNT_W'(T_VDD_LVDS);
    localparam logic [CNT_W-1:0] LIM_LVDS_BL  = CNT_W'(T_LVDS_BL);
    localparam logic [CNT_W-1:0] LIM_BL_LVDS  = CNT_W'(T_BL_LVDS);
    localparam logic [CNT_W-1:0] LIM_LVDS_VDD = CNT_W'(T_LVDS_VDD);
    localparam logic [CNT_W-1:0] LIM_OFF_MIN  = CNT_W'(T_OFF_MIN);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] limit;
    logic             tick;
    logic             state_chg;
    logic             done;
    logic             go;
    outs_t            outs_next;

    assign go        = I_power_req & I_pll_lock & ~I_fault;
    assign state_chg = (state_next != state);
    assign done      = (tick_cnt == limit);
    assign outs_next = decode_outs(state_next);
    assign O_state   = state;

    lvds_panel_pwr_seq_tick #(
        .CLK_PER_TICK (CLK_PER_TICK)
    ) u_tick (
        .clk   (I_pix_clk),
        .rst_n (I_rst_n),
        .clr   (state_chg),
        .tick  (tick)
    );

    // Delay selected by the current timed state; untimed states never use it.
    always_comb begin
        limit = '0;
        case (state)
            ST_UP_VDD:   limit = LIM_VDD_LVDS;
            ST_UP_LVDS:  limit = LIM_LVDS_BL;
            ST_DN_BL:    limit = LIM_BL_LVDS;
            ST_DN_LVDS:  limit = LIM_LVDS_VDD;
            ST_COOLDOWN: limit = LIM_OFF_MIN;
            default:     limit = '0;
        endcase
    end

    // Next state; abort beats timer expiry, fault skips straight to cooldown.
    always_comb begin
        state_next = state;
        case (state)
            ST_OFF:      if (go) state_next = ST_UP_VDD;
            ST_UP_VDD:   if (!go) state_next = ST_COOLDOWN;
                         else if (done) state_next = ST_UP_LVDS;
            ST_UP_LVDS:  if (!go) state_next = ST_DN_LVDS;
                         else if (done) state_next = ST_RUN;
            ST_RUN:      if (!go) state_next = ST_DN_BL;
            ST_DN_BL:    if (done) state_next = ST_DN_LVDS;
            ST_DN_LVDS:  if (done) state_next = ST_COOLDOWN;
            ST_COOLDOWN: if (done) state_next = ST_OFF;
            default:     state_next = ST_COOLDOWN;
        endcase
        if (I_fault && (state != ST_OFF) && (state != ST_COOLDOWN)) begin
            state_next = ST_COOLDOWN;
        end
    end

    // State, delay counter and outputs all move on the same edge.
    always_ff @(posedge I_pix_clk) begin
        if (!I_rst_n) begin
            state      <= ST_COOLDOWN;
            tick_cnt   <= '0;
            O_vdd_en   <= 1'b0;
            O_tx_rst_n <= 1'b0;
            O_video_en <= 1'b0;
            O_bl_en    <= 1'b0;
            O_ready    <= 1'b0;
        end else begin
            state <= state_next;
            if (state_chg) begin
                tick_cnt <= '0;
            end else if (tick && (tick_cnt != {CNT_W{1'b1}})) begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
            O_vdd_en   <= outs_next.vdd_en;
            O_tx_rst_n <= outs_next.tx_on;
            O_video_en <= outs_next.tx_on;
            O_bl_en    <= outs_next.bl_on;
            O_ready    <= outs_next.bl_on;
        end
    end

endmodule

// File: tb/tb_lvds_panel_pwr_seq.sv
// Bench for the LVDS panel power sequencer. Expected state segments (state and
// length in cycles, 0 = not timed) are queued as stimulus is applied and
// checked by a monitor whenever the DUT changes state.
module tb_lvds_panel_pwr_seq;

    typedef struct {
        int st;
        int len;
    } seg_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       power_req = 1'b1;
    logic       pll_lock = 1'b1;
    logic       fault = 1'b0;
    logic       vdd_en, tx_rst_n, video_en, bl_en, ready;
    logic [2:0] state;

    logic       rst2_n = 1'b0;
    logic       vdd_en2, tx_rst_n2, video_en2, bl_en2, ready2;
    logic [2:0] state2;

    int   n_chk = 0;
    int   n_fail = 0;
    seg_t sb_q[$];
    bit   mon_en = 1'b0;
    int   cur_st = 6;
    int   cur_len = 0;

    always #5 clk = ~clk;

    lvds_panel_pwr_seq #(
        .CLK_PER_TICK (4),
        .CNT_W        (8),
        .T_VDD_LVDS   (3),
        .T_LVDS_BL    (5),
        .T_BL_LVDS    (5),
        .T_LVDS_VDD   (3),
        .T_OFF_MIN    (10)
    ) u_dut (
        .I_pix_clk   (clk),
        .I_rst_n     (rst_n),
        .I_power_req (power_req),
        .I_pll_lock  (pll_lock),
        .I_fault     (fault),
        .O_vdd_en    (vdd_en),
        .O_tx_rst_n  (tx_rst_n),
        .O_video_en  (video_en),
        .O_bl_en     (bl_en),
        .O_ready     (ready),
        .O_state     (state)
    );

    lvds_panel_pwr_seq #(
        .CLK_PER_TICK (1),
        .CNT_W        (8),
        .T_VDD_LVDS   (3),
        .T_LVDS_BL    (0),
        .T_BL_LVDS    (2),
        .T_LVDS_VDD   (3),
        .T_OFF_MIN    (6)
    ) u_dut2 (
        .I_pix_clk   (clk),
        .I_rst_n     (rst2_n),
        .I_power_req (1'b1),
        .I_pll_lock  (1'b1),
        .I_fault     (1'b0),
        .O_vdd_en    (vdd_en2),
        .O_tx_rst_n  (tx_rst_n2),
        .O_video_en  (video_en2),
        .O_bl_en     (bl_en2),
        .O_ready     (ready2),
        .O_state     (state2)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // {vdd_en, tx_rst_n, video_en, bl_en, ready} expected in each state
    function automatic int exp_outs(input int s);
        case (s)
            1:       return 5'b10000;
            2:       return 5'b11100;
            3:       return 5'b11111;
            4:       return 5'b11100;
            5:       return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic int outs_now();
        return {27'd0, vdd_en, tx_rst_n, video_en, bl_en, ready};
    endfunction

    task automatic push(input int st, input int len);
        seg_t e;
        e.st  = st;
        e.len = len;
        sb_q.push_back(e);
    endtask

    // Wait (bounded) until the DUT enters state s; returns 1 ns after the edge.
    task automatic wait_st(input int s, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((int'(state) != s) && (n < budget));
        if (int'(state) != s) chk("timeout_state", int'(state), s);
    endtask

    task automatic seg2(input int st, input int len);
        int n;
        chk("d2_state", int'(state2), st);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((int'(state2) == st) && (n < 200));
        chk("d2_len", n, len);
    endtask

    // Segment monitor: on each state change, compare the finished segment.
    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(state) != cur_st) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", int'(state), -1);
                end else begin
                    seg_t e;
                    e = sb_q.pop_front();
                    chk("seg_state", cur_st, e.st);
                    if (e.len != 0) chk("seg_len", cur_len, e.len);
                end
                chk("seg_outs", outs_now(), exp_outs(int'(state)));
                cur_st  = int'(state);
                cur_len = 1;
            end else begin
                cur_len++;
            end
            if (!rst_n) cur_len = 0;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", int'(state), 6);
        chk("rst_outs", outs_now(), 0);
        mon_en = 1'b1;

        // Power-up from reset with request already present
        push(6, 41); push(0, 1); push(1, 13); push(2, 21); push(3, 0);
        rst_n = 1'b1;
        wait_st(3, 200);

        // Request drop in RUN: full reverse teardown
        repeat (5) @(posedge clk);
        #1;
        push(4, 21); push(5, 13); push(6, 41); push(0, 0);
        power_req = 1'b0;
        @(posedge clk);
        #1;
        chk("bl_fall", int'(bl_en), 0);
        chk("st_dn_bl", int'(state), 4);
        wait_st(0, 200);
        repeat (3) @(posedge clk);
        #1;

        // Lock loss in UP_LVDS, then request drop in UP_VDD
        push(1, 13); push(2, 4); push(5, 13); push(6, 41); push(0, 1);
        power_req = 1'b1;
        wait_st(2, 50);
        repeat (3) @(posedge clk);
        #1;
        pll_lock = 1'b0;
        wait_st(0, 200);
        push(1, 3); push(6, 41); push(0, 0);
        pll_lock = 1'b1;
        wait_st(1, 10);
        repeat (2) @(posedge clk);
        #1;
        power_req = 1'b0;
        wait_st(0, 100);
        repeat (3) @(posedge clk);
        #1;

        // One-cycle fault in RUN, request held: full cooldown then re-power
        push(1, 13); push(2, 21); push(3, 5); push(6, 41);
        push(0, 1); push(1, 13); push(2, 21); push(3, 1);
        power_req = 1'b1;
        wait_st(3, 100);
        repeat (4) @(posedge clk);
        #1;
        fault = 1'b1;
        @(posedge clk);
        #1;
        fault = 1'b0;
        chk("fault_state", int'(state), 6);
        chk("fault_outs", outs_now(), 0);
        wait_st(3, 200);

        // Request re-asserted during DN_BL is ignored until OFF
        push(4, 21); push(5, 13); push(6, 41); push(0, 1);
        push(1, 13); push(2, 21); push(3, 0);
        power_req = 1'b0;
        wait_st(4, 10);
        repeat (3) @(posedge clk);
        #1;
        power_req = 1'b1;
        wait_st(3, 300);

        // Synchronous reset in RUN
        repeat (3) @(posedge clk);
        #1;
        push(6, 41); push(0, 1); push(1, 13); push(2, 21); push(3, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_run_state", int'(state), 6);
        chk("rst_run_outs", outs_now(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_st(3, 200);

        // Abort on the same edge as UP_VDD timer expiry goes to COOLDOWN
        repeat (2) @(posedge clk);
        #1;
        push(4, 21); push(5, 13); push(6, 41); push(0, 1);
        push(1, 13); push(6, 41); push(0, 0);
        power_req = 1'b0;
        wait_st(0, 200);
        power_req = 1'b1;
        wait_st(1, 10);
        repeat (12) @(posedge clk);
        #1;
        power_req = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_vs_done", int'(state), 6);
        wait_st(0, 100);

        // CLK_PER_TICK=1 and T_LVDS_BL=0 instance
        rst2_n = 1'b1;
        seg2(6, 7);
        seg2(0, 1);
        seg2(1, 4);
        seg2(2, 1);
        chk("d2_run", int'(state2), 3);
        chk("d2_bl_en", int'(bl_en2), 1);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_left", sb_q.size(), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
